// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer
// Microcoded control sequencer for the 8-bit bus-based SAP datapath. It walks
// fetch (T0-T1) and execute (T2-T4) steps for a 4-bit opcode and decodes
// every load strobe, bus enable and the ALU add/sub select from the current
// state, opcode and ALU flags. Mealy decode: outputs are combinational.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   run                 : start/continue, sampled at instruction boundaries
//   ir_opcode[3:0]      : IR upper nibble
//   cf, zf              : registered ALU carry / zero flags
//   pc_out_en, pc_inc, pc_load_n, mar_load_n, ram_out_en, ram_we,
//   ir_load_n, ir_out_en, a_load_n, a_out_en, b_load_n, alu_out_en,
//   alu_sub, out_load_n : datapath controls (*_n are active-low)
//   tstate[2:0]         : current T-state, 0 in IDLE/HALT
//   instr_done          : last step of the current instruction
//   idle, halted        : status
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | waiting for run, no controls asserted
// T0     | fetch: PC -> MAR
// T1     | fetch: RAM -> IR, PC increments
// T2     | execute step 1 (opcode decoded)
// T3     | execute step 2 (LDA, STA, ADD, SUB)
// T4     | execute step 3 (ADD, SUB)
// HALT   | stopped by HLT, only rst leaves

module sap_control_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [3:0] ir_opcode,
   input  logic       cf,
   input  logic       zf,
   output logic       pc_out_en,
   output logic       pc_inc,
   output logic       pc_load_n,
   output logic       mar_load_n,
   output logic       ram_out_en,
   output logic       ram_we,
   output logic       ir_load_n,
   output logic       ir_out_en,
   output logic       a_load_n,
   output logic       a_out_en,
   output logic       b_load_n,
   output logic       alu_out_en,
   output logic       alu_sub,
   output logic       out_load_n,
   output logic [2:0] tstate,
   output logic       instr_done,
   output logic       idle,
   output logic       halted
);

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_HALT = 3'd6
   } state_t;

   state_t state_q, state_d;
   logic   last;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      last       = 1'b0;
      pc_out_en  = 1'b0;
      pc_inc     = 1'b0;
      pc_load_n  = 1'b1;
      mar_load_n = 1'b1;
      ram_out_en = 1'b0;
      ram_we     = 1'b0;
      ir_load_n  = 1'b1;
      ir_out_en  = 1'b0;
      a_load_n   = 1'b1;
      a_out_en   = 1'b0;
      b_load_n   = 1'b1;
      alu_out_en = 1'b0;
      alu_sub    = 1'b0;
      out_load_n = 1'b1;
      instr_done = 1'b0;

      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0: begin
            pc_out_en  = 1'b1;
            mar_load_n = 1'b0;
            state_d    = S_T1;
         end
         S_T1: begin
            ram_out_en = 1'b1;
            ir_load_n  = 1'b0;
            pc_inc     = 1'b1;
            state_d    = S_T2;
         end
         S_T2: begin
            case (ir_opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ir_out_en  = 1'b1;
                  mar_load_n = 1'b0;
                  state_d    = S_T3;
               end
               OP_LDI: begin
                  ir_out_en = 1'b1;
                  a_load_n  = 1'b0;
                  last      = 1'b1;
               end
               OP_JMP: begin
                  ir_out_en = 1'b1;
                  pc_load_n = 1'b0;
                  last      = 1'b1;
               end
               OP_JC: begin
                  ir_out_en = cf;
                  pc_load_n = ~cf;
                  last      = 1'b1;
               end
               OP_JZ: begin
                  ir_out_en = zf;
                  pc_load_n = ~zf;
                  last      = 1'b1;
               end
               OP_OUT: begin
                  a_out_en   = 1'b1;
                  out_load_n = 1'b0;
                  last       = 1'b1;
               end
               default: last = 1'b1;
            endcase
         end
         S_T3: begin
            case (ir_opcode)
               OP_LDA: begin
                  ram_out_en = 1'b1;
                  a_load_n   = 1'b0;
                  last       = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ram_out_en = 1'b1;
                  b_load_n   = 1'b0;
                  alu_sub    = (ir_opcode == OP_SUB);
                  state_d    = S_T4;
               end
               OP_STA: begin
                  a_out_en = 1'b1;
                  ram_we   = 1'b1;
                  last     = 1'b1;
               end
               // IR cannot change after T1, so this only ends a corrupted step
               default: last = 1'b1;
            endcase
         end
         S_T4: begin
            alu_out_en = 1'b1;
            a_load_n   = 1'b0;
            alu_sub    = (ir_opcode == OP_SUB);
            last       = 1'b1;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      if (last) begin
         instr_done = 1'b1;
         if (state_q == S_T2 && ir_opcode == OP_HLT) state_d = S_HALT;
         else if (run)                               state_d = S_T0;
         else                                        state_d = S_IDLE;
      end
   end

   always_comb begin
      case (state_q)
         S_T0:    tstate = 3'd0;
         S_T1:    tstate = 3'd1;
         S_T2:    tstate = 3'd2;
         S_T3:    tstate = 3'd3;
         S_T4:    tstate = 3'd4;
         default: tstate = 3'd0;
      endcase
   end

   assign idle   = (state_q == S_IDLE);
   assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Testbench for sap_control_sequencer: directed scenarios followed by random
// opcodes, flags, run and reset, each cycle compared to a step-count model.
module tb_sap_control_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [3:0] ir_opcode = 4'h0;
   logic       cf = 1'b0;
   logic       zf = 1'b0;
   logic       pc_out_en, pc_inc, pc_load_n, mar_load_n, ram_out_en, ram_we;
   logic       ir_load_n, ir_out_en, a_load_n, a_out_en, b_load_n;
   logic       alu_out_en, alu_sub, out_load_n, instr_done, idle, halted;
   logic [2:0] tstate;

   sap_control_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode), .cf(cf), .zf(zf),
      .pc_out_en(pc_out_en), .pc_inc(pc_inc), .pc_load_n(pc_load_n),
      .mar_load_n(mar_load_n), .ram_out_en(ram_out_en), .ram_we(ram_we),
      .ir_load_n(ir_load_n), .ir_out_en(ir_out_en), .a_load_n(a_load_n),
      .a_out_en(a_out_en), .b_load_n(b_load_n), .alu_out_en(alu_out_en),
      .alu_sub(alu_sub), .out_load_n(out_load_n), .tstate(tstate),
      .instr_done(instr_done), .idle(idle), .halted(halted)
   );

   always #5 clk = ~clk;

   // Active-high control bits, one per datapath action
   localparam logic [13:0] PC_OUT  = 14'h2000;
   localparam logic [13:0] PC_INC  = 14'h1000;
   localparam logic [13:0] PC_LD   = 14'h0800;
   localparam logic [13:0] MAR_LD  = 14'h0400;
   localparam logic [13:0] RAM_OUT = 14'h0200;
   localparam logic [13:0] RAM_WE  = 14'h0100;
   localparam logic [13:0] IR_LD   = 14'h0080;
   localparam logic [13:0] IR_OUT  = 14'h0040;
   localparam logic [13:0] A_LD    = 14'h0020;
   localparam logic [13:0] A_OUT   = 14'h0010;
   localparam logic [13:0] B_LD    = 14'h0008;
   localparam logic [13:0] ALU_OUT = 14'h0004;
   localparam logic [13:0] ALU_SUB = 14'h0002;
   localparam logic [13:0] OUT_LD  = 14'h0001;

   int vectors    = 0;
   int miscompares = 0;

   // Model: mode 0 = idle, 1 = executing step m_k of an instruction, 2 = halted
   int m_mode = 0;
   int m_k    = 0;

   function automatic int instr_len(input logic [3:0] op);
      if (op == 4'h1 || op == 4'h4) return 4;
      if (op == 4'h2 || op == 4'h3) return 5;
      return 3;
   endfunction

   function automatic logic [13:0] step_ctl(input int k, input logic [3:0] op,
                                            input logic c, input logic z);
      logic [13:0] sub;
      sub = (op == 4'h3) ? ALU_SUB : 14'h0;
      if (k == 0) return PC_OUT | MAR_LD;
      if (k == 1) return RAM_OUT | IR_LD | PC_INC;
      if (k == 2) begin
         if (op >= 4'h1 && op <= 4'h4) return IR_OUT | MAR_LD;
         if (op == 4'h5) return IR_OUT | A_LD;
         if (op == 4'h6 || (op == 4'h7 && c) || (op == 4'h8 && z)) return IR_OUT | PC_LD;
         if (op == 4'hE) return A_OUT | OUT_LD;
         return 14'h0;
      end
      if (k == 3) begin
         if (op == 4'h1) return RAM_OUT | A_LD;
         if (op == 4'h4) return A_OUT | RAM_WE;
         return RAM_OUT | B_LD | sub;
      end
      return ALU_OUT | A_LD | sub;
   endfunction

   task automatic cycle(input logic r, input logic rn, input logic [3:0] op,
                        input logic c, input logic z);
      logic [13:0] got, exp;
      logic [2:0]  exp_t;
      logic        exp_done, excl_ok;
      @(negedge clk);
      rst = r; run = rn; ir_opcode = op; cf = c; zf = z;
      #1;
      vectors++;
      got = {pc_out_en, pc_inc, ~pc_load_n, ~mar_load_n, ram_out_en, ram_we,
             ~ir_load_n, ir_out_en, ~a_load_n, a_out_en, ~b_load_n,
             alu_out_en, alu_sub, ~out_load_n};
      exp      = (m_mode == 1) ? step_ctl(m_k, op, c, z) : 14'h0;
      exp_t    = (m_mode == 1) ? 3'(m_k) : 3'd0;
      exp_done = (m_mode == 1) && (m_k == instr_len(op) - 1);
      excl_ok  = ($countones({pc_out_en, ram_out_en, ir_out_en, a_out_en, alu_out_en}) <= 1);

      assert (got === exp) else begin
         miscompares++;
         $error("FAIL ctl t=%0t op=%h observed=%h expected=%h", $time, op, got, exp);
      end
      assert (tstate === exp_t) else begin
         miscompares++;
         $error("FAIL tstate t=%0t observed=%0d expected=%0d", $time, tstate, exp_t);
      end
      assert (instr_done === exp_done) else begin
         miscompares++;
         $error("FAIL instr_done t=%0t observed=%b expected=%b", $time, instr_done, exp_done);
      end
      assert (idle === (m_mode == 0)) else begin
         miscompares++;
         $error("FAIL idle t=%0t observed=%b expected=%b", $time, idle, m_mode == 0);
      end
      assert (halted === (m_mode == 2)) else begin
         miscompares++;
         $error("FAIL halted t=%0t observed=%b expected=%b", $time, halted, m_mode == 2);
      end
      assert (excl_ok === 1'b1) else begin
         miscompares++;
         $error("FAIL bus_excl t=%0t observed=%b expected=1", $time, excl_ok);
      end

      if (r) begin
         m_mode = 0; m_k = 0;
      end else if (m_mode == 0) begin
         if (rn) begin m_mode = 1; m_k = 0; end
      end else if (m_mode == 1) begin
         if (m_k == instr_len(op) - 1) begin
            if (op == 4'hF) m_mode = 2;
            else if (rn)    m_k = 0;
            else            m_mode = 0;
         end else m_k++;
      end
   endtask

   // From IDLE: start one instruction and let it end in IDLE
   task automatic run_one(input logic [3:0] op, input logic c, input logic z);
      cycle(1'b0, 1'b1, op, c, z);
      for (int i = 0; i < instr_len(op) - 1; i++) cycle(1'b0, 1'b1, op, c, z);
      cycle(1'b0, 1'b0, op, c, z);
   endtask

   logic [3:0] cur_op;

   initial begin
      @(posedge clk);
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

      run_one(4'h2, 1'b0, 1'b0);
      run_one(4'h3, 1'b0, 1'b0);
      run_one(4'h7, 1'b1, 1'b0);
      run_one(4'h7, 1'b0, 1'b1);
      run_one(4'h8, 1'b0, 1'b1);
      run_one(4'h8, 1'b1, 1'b0);
      for (int op = 9; op <= 13; op++) run_one(4'(op), 1'b1, 1'b1);
      run_one(4'h1, 1'b0, 1'b0);
      run_one(4'h4, 1'b0, 1'b0);
      run_one(4'h5, 1'b0, 1'b0);
      run_one(4'h6, 1'b0, 1'b0);
      run_one(4'hE, 1'b0, 1'b0);
      run_one(4'h0, 1'b0, 1'b0);

      // HLT, then run toggling is ignored until a reset pulse
      run_one(4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i % 2), 4'(i), 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

      // LDA with run dropped in T1, then restart
      cycle(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
      run_one(4'h1, 1'b0, 1'b0);

      // Back-to-back instructions with no bubble, ADD then JZ
      cycle(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 4'h8, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 4'h8, 1'b0, 1'b1);

      // Random: opcode changes only at instruction boundaries (before IR load)
      cur_op = 4'h0;
      for (int i = 0; i < 4000; i++) begin
         if (m_mode != 1 || m_k == 0) cur_op = 4'($urandom_range(0, 15));
         cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 7) != 0),
               cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Microcoded control sequencer for the 8-bit bus-based datapath: program counter, MAR, RAM, instruction register, accumulator, B register, adder/subtractor and output register. Each cycle it drives every load strobe, tri-state enable and the ALU `sub` select, so that exactly one source drives the shared bus. It steps through fetch and execute T-states for a 4-bit opcode, branches on the ALU carry and zero flags, and stops on HLT. The block contains no datapath of its own; it is purely a state machine.

## Interface
Parameters: none (opcode map and T-state count are fixed).

Ports:
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `run` input 1: start/continue execution. Sampled at instruction boundaries.
- `ir_opcode` input 4: upper nibble of the instruction register.
- `cf` input 1: ALU carry flag (registered in the ALU).
- `zf` input 1: ALU zero flag (registered in the ALU).
- `pc_out_en` output 1: PC drives bus[3:0].
- `pc_inc` output 1: PC increments at the edge.
- `pc_load_n` output 1: PC loads from bus[3:0] at the edge; active-low.
- `mar_load_n` output 1: MAR loads from bus[3:0]; active-low.
- `ram_out_en` output 1: RAM[MAR] drives the bus.
- `ram_we` output 1: RAM[MAR] is written from the bus at the edge.
- `ir_load_n` output 1: IR loads from the bus; active-low.
- `ir_out_en` output 1: IR operand nibble drives bus[3:0].
- `a_load_n` output 1: accumulator loads from the bus; active-low.
- `a_out_en` output 1: accumulator drives the bus.
- `b_load_n` output 1: B register loads from the bus; active-low.
- `alu_out_en` output 1: ALU result drives the bus. The ALU flags update at this edge.
- `alu_sub` output 1: ALU select, 0 = add, 1 = subtract.
- `out_load_n` output 1: output register loads from the bus; active-low.
- `tstate` output 3: current T-state, 0–4. Reads 0 in IDLE and HALT.
- `instr_done` output 1: high during the last cycle of each instruction.
- `idle` output 1: high in IDLE.
- `halted` output 1: high in HALT.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, HALT.
- Reset: state becomes IDLE.
  - All `*_load_n` = 1.
  - All enables, `pc_inc`, `ram_we`, `alu_sub` and `instr_done` = 0.
  - `tstate` = 0, `idle` = 1, `halted` = 0.
  - A reset in any state, including mid-instruction, takes effect at the next edge.
- IDLE: no controls asserted. Goes to T0 on the edge where `run` = 1.
- Fetch, identical for all opcodes:
  - T0: `pc_out_en`, `mar_load_n` = 0.
  - T1: `ram_out_en`, `ir_load_n` = 0, `pc_inc`.
- Execute: `ir_opcode` is decoded combinationally in T2–T4 (IR is stable from the end of T1).
  - 0x0 NOP: T2 nothing; last.
  - 0x1 LDA: T2 `ir_out_en`, `mar_load_n`. T3 `ram_out_en`, `a_load_n`; last.
  - 0x2 ADD: T2 `ir_out_en`, `mar_load_n`. T3 `ram_out_en`, `b_load_n`. T4 `alu_out_en`, `a_load_n`, `alu_sub` = 0; last.
  - 0x3 SUB: same as ADD, but `alu_sub` = 1 in T3 and T4.
  - 0x4 STA: T2 `ir_out_en`, `mar_load_n`. T3 `a_out_en`, `ram_we`; last.
  - 0x5 LDI: T2 `ir_out_en`, `a_load_n`; last.
  - 0x6 JMP: T2 `ir_out_en`, `pc_load_n`; last.
  - 0x7 JC: T2 same as JMP if `cf` = 1, otherwise nothing; last.
  - 0x8 JZ: T2 same as JMP if `zf` = 1, otherwise nothing; last.
  - 0xE OUT: T2 `a_out_en`, `out_load_n`; last.
  - 0xF HLT: T2 nothing; last; next state is HALT.
  - 0x9–0xD: executed as NOP.
- After the last step: next state is T0 if `run` = 1, IDLE if `run` = 0.
  - Dropping `run` never aborts an instruction in progress.
- HALT: no controls asserted. Only `rst` exits HALT; `run` is ignored.
- Bus-exclusivity invariant: in every cycle, at most one of `pc_out_en`, `ram_out_en`, `ir_out_en`, `a_out_en`, `alu_out_en` is high.
- Control outputs are a pure function of state, `ir_opcode`, `cf` and `zf` (Mealy decode). Implementations may register them, provided the cycle alignment below holds.

## Timing
- A control asserted in state Tn takes effect at the rising edge that ends Tn.
- Instruction lengths:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, OUT, HLT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.
- IDLE→T0 latency: 1 edge after `run` is sampled high.
- Back-to-back instructions: T0 follows the last step immediately, with no bubble.
- `cf` and `zf` are sampled during JC/JZ T2. A flag updated at the T4 edge of the previous ADD/SUB is valid at that point.
- `instr_done` is high exactly one cycle per instruction, coincident with the last step.
- `halted` rises the cycle after HLT T2 and stays high until reset.

## Test plan
- Reset with `run` = 0: all load_n = 1, all enables = 0, `idle` = 1, `tstate` = 0. Hold 10 cycles: no change.
- `run` = 1, opcode 0x2 (ADD): sequence of `tstate` is 0,1,2,3,4,0. Checks:
  - T4 has `alu_out_en` = 1, `a_load_n` = 0, `alu_sub` = 0.
  - `instr_done` is high only in T4.
  - Repeat with 0x3: `alu_sub` = 1 in T3 and T4.
- JC with `cf` = 1: T2 has `ir_out_en` = 1, `pc_load_n` = 0. With `cf` = 0: T2 has every control inactive. Repeat for JZ/`zf`.
- Opcode 0xF: after 3 cycles `halted` = 1. Toggling `run` for 20 cycles changes nothing. `rst` pulse → `idle` = 1, `halted` = 0.
- Drop `run` in T1 of LDA: T2 and T3 complete normally, then state is IDLE. Re-raise `run` → T0 on the next edge.
- Random opcodes 0x0–0xF, `cf`/`zf` random, `rst` injected mid-instruction. Checks:
  - Bus-exclusivity invariant holds every cycle.
  - 0x9–0xD behave as NOP (3 cycles, no controls in T2).
  - After any reset, state is IDLE with all controls inactive.
